// File: rtl/sp_ram_arbiter_pkg.sv
// Shared constants and helpers for the single-port RAM arbiter.
package sp_ram_arb_pkg;

  localparam int RAM_DATA_WIDTH = 32;
  localparam int RAM_BE_WIDTH   = 4;

  // Width of an encoded port index; never narrower than one bit.
  function automatic int port_idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sp_ram_arbiter_if.sv
// Requester-side bus of the RAM arbiter: per-port request lanes and responses.
interface sp_ram_arbiter_if
  import sp_ram_arb_pkg::*;
#(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 15
);

  logic [NUM_PORTS-1:0]                     req;
  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0]     addr;
  logic [NUM_PORTS-1:0]                     we;
  logic [NUM_PORTS-1:0][RAM_BE_WIDTH-1:0]   be;
  logic [NUM_PORTS-1:0][RAM_DATA_WIDTH-1:0] wdata;
  logic [NUM_PORTS-1:0]                     gnt;
  logic [NUM_PORTS-1:0]                     rvalid;
  logic [NUM_PORTS-1:0][RAM_DATA_WIDTH-1:0] rdata;

  // Requesters drive the request lanes and observe grant/response.
  modport master (
    output req, addr, we, be, wdata,
    input  gnt, rvalid, rdata
  );

  // The arbiter consumes the request lanes and drives grant/response.
  modport slave (
    input  req, addr, we, be, wdata,
    output gnt, rvalid, rdata
  );

endinterface

// File: rtl/sp_ram_arbiter_rr_arb.sv
// Round-robin arbiter: rotating priority pointer, one-hot grant and encoded index.
module sp_ram_rr_arb
  import sp_ram_arb_pkg::*;
#(
  parameter  int NUM_PORTS = 2,
  localparam int IDX_W     = port_idx_width(NUM_PORTS)
) (
  input  logic                 clk,
  input  logic                 rst_i,
  input  logic [NUM_PORTS-1:0] req_i,
  output logic [NUM_PORTS-1:0] gnt_o,
  output logic [IDX_W-1:0]     idx_o,
  output logic                 vld_o
);

  logic [IDX_W-1:0] prio_q;
  logic [IDX_W-1:0] prio_d;
  logic [IDX_W-1:0] p_idx;

  // Scan requesters starting at the pointer; the first hit wins the grant.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    vld_o = 1'b0;
    p_idx = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      p_idx = IDX_W'((int'(prio_q) + o) % NUM_PORTS);
      if (!vld_o && req_i[p_idx]) begin
        vld_o        = 1'b1;
        gnt_o[p_idx] = 1'b1;
        idx_o        = p_idx;
      end
    end
  end

  // Pointer moves just past the granted port; it holds when nothing is granted.
  always_comb begin
    prio_d = prio_q;
    if (vld_o) begin
      prio_d = (int'(idx_o) == NUM_PORTS - 1) ? '0 : idx_o + IDX_W'(1);
    end
  end

  // Priority pointer register.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      prio_q <= '0;
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule

// File: rtl/sp_ram_arbiter.sv
// Shares one single-port word RAM between NUM_PORTS requesters with
// round-robin arbitration, 1-cycle responses and a contention counter.
module sp_ram_arbiter
  import sp_ram_arb_pkg::*;
#(
  parameter  int NUM_PORTS  = 2,
  parameter  int ADDR_WIDTH = 15,
  parameter  int CNT_WIDTH  = 32,
  localparam int IDX_W      = port_idx_width(NUM_PORTS)
) (
  input  logic                      clk,
  input  logic                      rst_i,
  sp_ram_arbiter_if.slave           bus_if,
  output logic                      ram_en_o,
  output logic                      ram_we_o,
  output logic [ADDR_WIDTH-1:0]     ram_addr_o,
  output logic [RAM_DATA_WIDTH-1:0] ram_wdata_o,
  output logic [RAM_BE_WIDTH-1:0]   ram_be_o,
  input  logic [RAM_DATA_WIDTH-1:0] ram_rdata_i,
  input  logic                      cnt_clr_i,
  output logic [CNT_WIDTH-1:0]      conflict_cnt_o
);

  logic [IDX_W-1:0]     gnt_idx;
  logic                 gnt_vld;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [IDX_W-1:0]     rsp_id_q, rsp_id_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  int                   n_req;

  sp_ram_rr_arb #(
    .NUM_PORTS (NUM_PORTS)
  ) u_arb (
    .clk   (clk),
    .rst_i (rst_i),
    .req_i (bus_if.req),
    .gnt_o (bus_if.gnt),
    .idx_o (gnt_idx),
    .vld_o (gnt_vld)
  );

  // Steer the granted port onto the RAM; everything is zero when idle.
  always_comb begin
    ram_en_o    = 1'b0;
    ram_we_o    = 1'b0;
    ram_addr_o  = '0;
    ram_wdata_o = '0;
    ram_be_o    = '0;
    if (gnt_vld) begin
      ram_en_o    = 1'b1;
      ram_we_o    = bus_if.we[gnt_idx];
      ram_addr_o  = bus_if.addr[gnt_idx];
      ram_wdata_o = bus_if.wdata[gnt_idx];
      ram_be_o    = bus_if.be[gnt_idx];
    end
  end

  // Remember who was granted so the response lands on that port next cycle.
  always_comb begin
    rsp_valid_d = gnt_vld;
    rsp_id_d    = gnt_vld ? gnt_idx : rsp_id_q;
  end

  // Response tracking registers.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
    end
  end

  // Decode the response to its port; read data is broadcast to every port.
  always_comb begin
    bus_if.rvalid = '0;
    bus_if.rdata  = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      bus_if.rvalid[i] = rsp_valid_q && (rsp_id_q == IDX_W'(i));
      bus_if.rdata[i]  = ram_rdata_i;
    end
  end

  // Saturating count of cycles with two or more requesters; clear has priority.
  always_comb begin
    n_req = 0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      n_req = n_req + int'(bus_if.req[i]);
    end
    cnt_d = cnt_q;
    if (cnt_clr_i) begin
      cnt_d = '0;
    end else if (n_req >= 2 && cnt_q != '1) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  // Contention counter register.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign conflict_cnt_o = cnt_q;

endmodule

// File: tb/tb_sp_ram_arbiter.sv
// Bench for sp_ram_arbiter: three ports, small RAM model, table of per-cycle
// vectors plus hand sequences for reset and pointer behaviour.
module tb_sp_ram_arbiter;

  localparam int NP = 3;
  localparam int AW = 8;
  localparam int CW = 4;

  typedef struct {
    logic [NP-1:0] req;
    logic [NP-1:0] we;
    logic [NP-1:0] gnt;
    logic [3:0]    be;
    logic [31:0]   wd;
    logic          clr;
    logic          chk_cnt;
    logic [CW-1:0] cnt;
  } vec_t;

  typedef struct {
    int          id;
    bit          rd;
    logic [31:0] data;
  } rsp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata, ram_rdata;
  logic [3:0]    ram_be;
  logic          cnt_clr;
  logic [CW-1:0] cnt;

  logic [31:0]   mem    [0:255];
  logic [31:0]   shadow [0:255];
  rsp_t          sb[$];
  vec_t          tbl[$];
  int            n_chk  = 0;
  int            n_fail = 0;

  sp_ram_arbiter_if #(.NUM_PORTS(NP), .ADDR_WIDTH(AW)) bus ();

  sp_ram_arbiter #(
    .NUM_PORTS  (NP),
    .ADDR_WIDTH (AW),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk            (clk),
    .rst_i          (rst),
    .bus_if         (bus),
    .ram_en_o       (ram_en),
    .ram_we_o       (ram_we),
    .ram_addr_o     (ram_addr),
    .ram_wdata_o    (ram_wdata),
    .ram_be_o       (ram_be),
    .ram_rdata_i    (ram_rdata),
    .cnt_clr_i      (cnt_clr),
    .conflict_cnt_o (cnt)
  );

  always #5 clk = ~clk;

  // Behavioural single-port RAM with byte enables and 1-cycle read latency.
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) begin
        for (int b = 0; b < 4; b++) begin
          if (ram_be[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
        end
      end else begin
        ram_rdata <= mem[ram_addr];
      end
    end
  end

  task automatic chk(input string name, input int n, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (step %0d): got %0h, required %0h", name, n, act, exp);
    end
  endtask

  function automatic vec_t mk(logic [NP-1:0] req, logic [NP-1:0] we, logic [NP-1:0] gnt,
                              logic [3:0] be, logic [31:0] wd, logic clr, logic chk_cnt,
                              logic [CW-1:0] c);
    vec_t v;
    v.req = req; v.we = we; v.gnt = gnt; v.be = be; v.wd = wd;
    v.clr = clr; v.chk_cnt = chk_cnt; v.cnt = c;
    return v;
  endfunction

  function automatic logic [AW-1:0] port_addr(int p);
    return AW'(16 * (p + 1));
  endfunction

  function automatic logic [3:0] port_be(vec_t v, int p);
    return v.we[p] ? v.be : 4'(p + 1);
  endfunction

  function automatic logic [31:0] port_wd(vec_t v, int p);
    return v.we[p] ? v.wd : (32'hA5A5_0000 + 32'(p));
  endfunction

  // Drive one cycle, check outputs at the falling edge, update the scoreboard.
  task automatic run_vec(input vec_t v, input int n);
    int   k;
    rsp_t e;
    logic [31:0] w;
    for (int p = 0; p < NP; p++) begin
      bus.req[p]   = v.req[p];
      bus.we[p]    = v.we[p];
      bus.addr[p]  = port_addr(p);
      bus.be[p]    = port_be(v, p);
      bus.wdata[p] = port_wd(v, p);
    end
    cnt_clr = v.clr;
    @(negedge clk);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("rvalid", n, 64'(bus.rvalid), 64'(3'b001 << e.id));
      if (e.rd) chk("rdata", n, 64'(bus.rdata[e.id]), 64'(e.data));
    end else begin
      chk("rvalid_idle", n, 64'(bus.rvalid), 64'd0);
    end
    chk("gnt", n, 64'(bus.gnt), 64'(v.gnt));
    k = -1;
    for (int p = 0; p < NP; p++) if (v.gnt[p]) k = p;
    if (k >= 0) begin
      chk("ram_en", n, 64'(ram_en), 64'd1);
      chk("ram_we", n, 64'(ram_we), 64'(v.we[k]));
      chk("ram_addr", n, 64'(ram_addr), 64'(port_addr(k)));
      chk("ram_be", n, 64'(ram_be), 64'(port_be(v, k)));
      chk("ram_wdata", n, 64'(ram_wdata), 64'(port_wd(v, k)));
      if (v.we[k]) begin
        w = shadow[port_addr(k)];
        for (int b = 0; b < 4; b++) if (v.be[b]) w[8*b +: 8] = v.wd[8*b +: 8];
        shadow[port_addr(k)] = w;
        sb.push_back('{id: k, rd: 1'b0, data: 32'd0});
      end else begin
        sb.push_back('{id: k, rd: 1'b1, data: shadow[port_addr(k)]});
      end
    end else begin
      chk("ram_en_idle", n, 64'(ram_en), 64'd0);
      chk("ram_we_idle", n, 64'(ram_we), 64'd0);
      chk("ram_addr_idle", n, 64'(ram_addr), 64'd0);
    end
    if (v.chk_cnt) chk("conflict_cnt", n, 64'(cnt), 64'(v.cnt));
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst     = 1'b1;
    cnt_clr = 1'b0;
    bus.req = '0; bus.we = '0; bus.addr = '0; bus.be = '0; bus.wdata = '0;

    // Single writes/reads, byte write, contention, rotation, drop, saturation, clear.
    tbl.push_back(mk(3'b001, 3'b001, 3'b001, 4'hF, 32'hDEADBEEF, 0, 0, 0));
    tbl.push_back(mk(3'b001, 3'b000, 3'b001, 4'hF, 32'h0,        0, 0, 0));
    tbl.push_back(mk(3'b000, 3'b000, 3'b000, 4'h0, 32'h0,        0, 0, 0));
    tbl.push_back(mk(3'b000, 3'b000, 3'b000, 4'h0, 32'h0,        0, 0, 0));
    tbl.push_back(mk(3'b010, 3'b010, 3'b010, 4'hF, 32'hFFFFFFFF, 0, 0, 0));
    tbl.push_back(mk(3'b010, 3'b010, 3'b010, 4'h2, 32'h0000AB00, 0, 0, 0));
    tbl.push_back(mk(3'b010, 3'b000, 3'b010, 4'h0, 32'h0,        0, 0, 0));
    tbl.push_back(mk(3'b000, 3'b000, 3'b000, 4'h0, 32'h0,        0, 0, 0));
    tbl.push_back(mk(3'b000, 3'b000, 3'b000, 4'h0, 32'h0,        1, 0, 0));
    tbl.push_back(mk(3'b011, 3'b000, 3'b001, 4'h0, 32'h0,        0, 1, 0));
    tbl.push_back(mk(3'b011, 3'b000, 3'b010, 4'h0, 32'h0,        0, 0, 0));
    tbl.push_back(mk(3'b011, 3'b000, 3'b001, 4'h0, 32'h0,        0, 0, 0));
    tbl.push_back(mk(3'b011, 3'b000, 3'b010, 4'h0, 32'h0,        0, 0, 0));
    tbl.push_back(mk(3'b000, 3'b000, 3'b000, 4'h0, 32'h0,        0, 1, 4));
    tbl.push_back(mk(3'b100, 3'b100, 3'b100, 4'hF, 32'h12345678, 0, 0, 0));
    tbl.push_back(mk(3'b111, 3'b000, 3'b001, 4'h0, 32'h0,        0, 0, 0));
    tbl.push_back(mk(3'b111, 3'b000, 3'b010, 4'h0, 32'h0,        0, 0, 0));
    tbl.push_back(mk(3'b111, 3'b000, 3'b100, 4'h0, 32'h0,        0, 0, 0));
    tbl.push_back(mk(3'b011, 3'b000, 3'b001, 4'h0, 32'h0,        0, 0, 0));
    tbl.push_back(mk(3'b011, 3'b000, 3'b010, 4'h0, 32'h0,        0, 0, 0));
    tbl.push_back(mk(3'b011, 3'b000, 3'b001, 4'h0, 32'h0,        0, 0, 0));
    tbl.push_back(mk(3'b011, 3'b000, 3'b010, 4'h0, 32'h0,        0, 0, 0));
    tbl.push_back(mk(3'b000, 3'b000, 3'b000, 4'h0, 32'h0,        0, 1, 11));
    tbl.push_back(mk(3'b011, 3'b000, 3'b001, 4'h0, 32'h0,        0, 0, 0));
    tbl.push_back(mk(3'b000, 3'b000, 3'b000, 4'h0, 32'h0,        0, 1, 12));
    tbl.push_back(mk(3'b110, 3'b000, 3'b010, 4'h0, 32'h0,        0, 0, 0));
    tbl.push_back(mk(3'b111, 3'b000, 3'b100, 4'h0, 32'h0,        0, 1, 13));
    tbl.push_back(mk(3'b111, 3'b000, 3'b001, 4'h0, 32'h0,        0, 1, 14));
    tbl.push_back(mk(3'b111, 3'b000, 3'b010, 4'h0, 32'h0,        0, 1, 15));
    tbl.push_back(mk(3'b111, 3'b000, 3'b100, 4'h0, 32'h0,        0, 1, 15));
    tbl.push_back(mk(3'b111, 3'b000, 3'b001, 4'h0, 32'h0,        0, 1, 15));
    tbl.push_back(mk(3'b111, 3'b000, 3'b010, 4'h0, 32'h0,        1, 1, 15));
    tbl.push_back(mk(3'b000, 3'b000, 3'b000, 4'h0, 32'h0,        0, 1, 0));

    // Reset: outputs idle, grant stays combinational while reset is held.
    @(posedge clk);
    #1;
    bus.req = 3'b010;
    @(negedge clk);
    chk("reset_rvalid", -1, 64'(bus.rvalid), 64'd0);
    chk("reset_cnt", -1, 64'(cnt), 64'd0);
    chk("reset_gnt_comb", -1, 64'(bus.gnt), 64'(3'b010));
    chk("reset_ram_en_comb", -1, 64'(ram_en), 64'd1);
    @(posedge clk);
    #1;
    bus.req = '0;
    rst     = 1'b0;

    foreach (tbl[i]) run_vec(tbl[i], i);

    // Read grant to port 1 moves the pointer to 2, then reset hits while
    // its response is outstanding: the response is lost, pointer back to 0.
    run_vec(mk(3'b010, 3'b000, 3'b010, 4'h0, 32'h0, 0, 0, 0), 100);
    bus.req = '0;
    rst     = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    run_vec(mk(3'b111, 3'b000, 3'b001, 4'h0, 32'h0, 0, 1, 0), 101);
    run_vec(mk(3'b000, 3'b000, 3'b000, 4'h0, 32'h0, 0, 1, 1), 102);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sp_ram_arbiter.md
# sp_ram_arbiter

Shares one single-port word RAM (`sp_ram_wrap`) between `NUM_PORTS` requesters, e.g. core instruction fetch, core data and debug/AXI bridge. Round-robin arbitration grants at most one access per cycle and returns read data and write acknowledges one cycle later. A saturating contention counter supports performance analysis. Sits directly in front of the RAM wrapper; RAM-side ports connect 1:1 to its `en_i/addr_i/wdata_i/we_i/be_i/rdata_o`.

## Interface

Parameters:
- `NUM_PORTS`, 2: number of requesters, 2..8.
- `ADDR_WIDTH`, 15: word address width; must match the RAM wrapper.
- `CNT_WIDTH`, 32: contention counter width.

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `rst_i`  in  1  reset; synchronous, active-high.
- `req_i`  in  NUM_PORTS  per-port access request.
- `addr_i`  in  NUM_PORTS×ADDR_WIDTH  per-port word address.
- `we_i`  in  NUM_PORTS  per-port write enable (1 = write).
- `be_i`  in  NUM_PORTS×4  per-port byte enables.
- `wdata_i`  in  NUM_PORTS×32  per-port write data.
- `gnt_o`  out  NUM_PORTS  one-hot grant, combinational from `req_i`.
- `rvalid_o`  out  NUM_PORTS  response valid, one cycle after grant.
- `rdata_o`  out  NUM_PORTS×32  read data; all ports carry `ram_rdata_i`.
- `ram_en_o`, `ram_we_o`  out  1  RAM enable / write.
- `ram_addr_o`  out  ADDR_WIDTH  RAM address.
- `ram_wdata_o`  out  32  RAM write data.
- `ram_be_o`  out  4  RAM byte enables.
- `ram_rdata_i`  in  32  RAM read data (1-cycle latency).
- `cnt_clr_i`  in  1  clear contention counter.
- `conflict_cnt_o`  out  CNT_WIDTH  cycles with ≥2 simultaneous requests.

## Operation

- Priority pointer `prio_q` (index, reset 0). Search order: `prio_q`, `prio_q+1`, … mod NUM_PORTS. First requesting port k gets `gnt_o[k]=1`.
- On any grant to k: `prio_q <= (k+1) mod NUM_PORTS`. No grant: pointer holds.
- RAM mux: `ram_en_o = |req_i`; addr/wdata/be/we taken from granted port. No grant: `ram_en_o=0`, `ram_we_o=0`, other RAM outputs 0.
- Response tracking: `rsp_valid_q <= |gnt_o`, `rsp_id_q <= k`. `rvalid_o[i] = rsp_valid_q && rsp_id_q==i`. Issued for reads and writes; rdata is meaningful only for reads.
- Requester rule: `req_i/addr_i/we_i/be_i/wdata_i` stay stable until `gnt_o`. A request deasserted before grant is dropped silently.
- Back-to-back: a port may request again in its `rvalid_o` cycle. One port requesting continuously alone is granted every cycle.
- Counter: increments each cycle where popcount(`req_i`) ≥ 2 and saturates at all-ones. `cnt_clr_i` wins over a simultaneous increment, so the result is 0.

## Timing

- Reset values: `prio_q=0`, `rsp_valid_q=0`, `rsp_id_q=0`, `conflict_cnt_o=0`. Hence `rvalid_o=0`.
- `rdata_o` follows `ram_rdata_i` and has no reset requirement.
- `gnt_o` and RAM outputs are combinational from `req_i` during reset; RAM writes may occur.
- Grant latency: 0 cycles (same cycle as `req_i`) with no contention; worst case NUM_PORTS-1 cycles.
- Response latency: exactly 1 cycle after grant.
- Reset while a response is pending: `rvalid_o` is 0 in the cycle after reset; the response is lost and requesters re-issue.
- No combinational path from `ram_rdata_i` to any control output.

## Structure

- Package `sp_ram_arb_pkg`: `RAM_DATA_WIDTH=32`, `RAM_BE_WIDTH=4`, and function `port_idx_width(n)` returning `$clog2` with a floor of 1.
- Sub-module `sp_ram_rr_arb` holds the pointer register and one-hot grant plus encoded index generation. It is reusable and verified stand-alone.
- Top holds the request mux, response registers and counter.

## Test plan

- Single port 0 writes 0xDEADBEEF, be=0xF, addr 0x10, then reads addr 0x10 → `gnt_o[0]` same cycle each time; `rvalid_o[0]` the next cycle; read returns 0xDEADBEEF.
- Ports 0 and 1 request continuously from reset → grants alternate 0,1,0,1. `conflict_cnt_o` equals the number of cycles both requested.
- NUM_PORTS=3, all request; port 2 deasserts after first grant → order 0,1,2,0,1,0,1. No `rvalid_o` for an ungranted cycle.
- Byte write be=0x2, data 0x0000AB00 over 0xFFFFFFFF, then read → 0xFFFFABFF.
- Counter preloaded to all-ones by forcing, with contention present → holds all-ones. Assert `cnt_clr_i` in a contention cycle → 0 next cycle.
- Reset asserted the cycle after a read grant → `rvalid_o` stays 0 and `prio_q` returns to 0. The next simultaneous request grants port 0.
